mux_scan_serializer: RTL and testbench

- Controller that sequences a 32:1 bit multiplexer to serialize a parallel word onto a single-bit stream.
- Accepts a word plus length via valid/ready, steps the mux select once per accepted output beat, and flags the final bit.
- Sits between a parallel producer and a bit-serial consumer (shift link, LED/scan chain driver).

---
 rtl/mux_scan_serializer_pkg.sv | 20 ++
 rtl/mux_scan_serializer_if.sv | 32 +++
 rtl/mux_scan_serializer_mux.sv | 14 +
 rtl/mux_scan_serializer.sv | 143 ++++++++++++++
 tb/tb_mux_scan_serializer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and constants for the mux-sequenced bit serializer.
// State encoding, default geometry and the start-select helper.
package mux_scan_serializer_pkg;

   localparam int SER_WIDTH = 32;
   localparam int SER_SEL_W = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      PARITY = 2'd2
   } state_e;

   // First select of a word: bit 0 when LSB-first, top bit when MSB-first.
   function automatic int unsigned start_sel(input bit msb_first, input int sel_w);
      if (msb_first) return (32'd1 << sel_w) - 32'd1;
      return 32'd0;
   endfunction

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Parallel-in / serial-out bus of the serializer, with producer/consumer
// side (master) and serializer side (slave) modports.
interface mux_scan_serializer_if
   import mux_scan_serializer_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH,
   parameter int SEL_W = SER_SEL_W
);

   // Both channels are valid/ready: a transfer happens on every rising clock
   // edge where valid and ready are both high; once valid is raised the
   // payload is held until that transfer, and ready may depend on valid.
   logic [WIDTH-1:0] in_data;
   logic [SEL_W-1:0] in_len;
   logic             in_valid;
   logic             in_ready;
   logic             out_bit;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport slave (
      input  in_data, in_len, in_valid, out_ready,
      output in_ready, out_bit, out_valid, out_last
   );

   modport master (
      output in_data, in_len, in_valid, out_ready,
      input  in_ready, out_bit, out_valid, out_last
   );

endinterface

// File: rtl/mux_scan_serializer_mux.sv
// Plain 2**SEL_W : 1 bit multiplexer; Y is I[S], purely combinational.
module mux_scan_serializer_mux
   import mux_scan_serializer_pkg::*;
#(
   parameter int SEL_W = SER_SEL_W
) (
   input  logic [SEL_W-1:0]      S,
   input  logic [(1<<SEL_W)-1:0] I,
   output logic                  Y
);

   assign Y = I[S];

endmodule

// File: rtl/mux_scan_serializer.sv
// Serializes a parallel word through a bit mux, one bit per accepted beat.
// Optional build macro SERIAL_PARITY_EN appends an even-parity beat per word.
module mux_scan_serializer
   import mux_scan_serializer_pkg::*;
#(
   parameter int WIDTH     = SER_WIDTH,
   parameter int SEL_W     = SER_SEL_W,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mux_scan_serializer_if.slave   bus,
   output logic [SEL_W-1:0]       sel,
   output logic                   busy,
   output state_e                 dbg_state
);

   localparam logic [SEL_W-1:0] SEL_START = SEL_W'(start_sel(MSB_FIRST, SEL_W));

   state_e           state;
   state_e           state_nxt;
   logic [WIDTH-1:0] data_reg;
   logic [SEL_W-1:0] len_reg;
   logic [SEL_W-1:0] cnt;
   logic             mux_bit;
   logic             data_last;
   logic             load;
   logic             beat;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             out_last_c;
   logic             out_bit_c;
`ifdef SERIAL_PARITY_EN
   logic             par_acc;
`endif

   mux_scan_serializer_mux #(.SEL_W(SEL_W)) u_mux (
      .S (sel),
      .I (data_reg),
      .Y (mux_bit)
   );

   assign data_last = (cnt == len_reg);
   assign load      = bus.in_valid & in_ready_c;
   assign beat      = out_valid_c & bus.out_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a word offered on the final beat reloads straight into SCAN
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (load) state_nxt = SCAN;
         end
         SCAN: begin
            if (beat && data_last) begin
`ifdef SERIAL_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = load ? SCAN : IDLE;
`endif
            end
         end
`ifdef SERIAL_PARITY_EN
         PARITY: begin
            if (beat) state_nxt = load ? SCAN : IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      out_last_c  = 1'b0;
      out_bit_c   = mux_bit;
      unique case (state)
         IDLE: begin
            in_ready_c = rst_n;
         end
         SCAN: begin
            out_valid_c = 1'b1;
`ifndef SERIAL_PARITY_EN
            out_last_c  = data_last;
            in_ready_c  = data_last & bus.out_ready;
`endif
         end
`ifdef SERIAL_PARITY_EN
         PARITY: begin
            out_valid_c = 1'b1;
            out_last_c  = 1'b1;
            out_bit_c   = par_acc;
            in_ready_c  = bus.out_ready;
         end
`endif
         default: ;
      endcase
   end

   // Word capture and select stepping; a load always wins over beat advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg <= '0;
         len_reg  <= '0;
         cnt      <= '0;
         sel      <= SEL_START;
`ifdef SERIAL_PARITY_EN
         par_acc  <= 1'b0;
`endif
      end else if (load) begin
         data_reg <= bus.in_data;
         len_reg  <= bus.in_len;
         cnt      <= '0;
         sel      <= SEL_START;
`ifdef SERIAL_PARITY_EN
         par_acc  <= 1'b0;
`endif
      end else if (state == SCAN && beat) begin
`ifdef SERIAL_PARITY_EN
         par_acc <= par_acc ^ mux_bit;
`endif
         if (!data_last) begin
            cnt <= cnt + SEL_W'(1);
            sel <= MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_last  = out_last_c;
   assign bus.out_bit   = out_bit_c;
   assign busy          = (state != IDLE);
   assign dbg_state     = state;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: an LSB-first and an MSB-first instance,
// directed steps plus random words checked against a bit-index model.
module tb_mux_scan_serializer;
   import mux_scan_serializer_pkg::*;

   localparam int W         = 32;
   localparam int SW        = 5;
   localparam int DRAIN_MAX = 600;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [W-1:0]  in_data   [2];
   logic [SW-1:0] in_len    [2];
   logic          in_valid  [2];
   logic          out_ready [2];
   logic          in_ready  [2];
   logic          out_bit   [2];
   logic          out_valid [2];
   logic          out_last  [2];
   logic          busy      [2];
   logic [SW-1:0] sel       [2];
   state_e        st        [2];

   mux_scan_serializer_if #(.WIDTH(W), .SEL_W(SW)) bus0 ();
   mux_scan_serializer_if #(.WIDTH(W), .SEL_W(SW)) bus1 ();

   assign bus0.in_data   = in_data[0];
   assign bus0.in_len    = in_len[0];
   assign bus0.in_valid  = in_valid[0];
   assign bus0.out_ready = out_ready[0];
   assign in_ready[0]    = bus0.in_ready;
   assign out_bit[0]     = bus0.out_bit;
   assign out_valid[0]   = bus0.out_valid;
   assign out_last[0]    = bus0.out_last;

   assign bus1.in_data   = in_data[1];
   assign bus1.in_len    = in_len[1];
   assign bus1.in_valid  = in_valid[1];
   assign bus1.out_ready = out_ready[1];
   assign in_ready[1]    = bus1.in_ready;
   assign out_bit[1]     = bus1.out_bit;
   assign out_valid[1]   = bus1.out_valid;
   assign out_last[1]    = bus1.out_last;

   mux_scan_serializer #(.WIDTH(W), .SEL_W(SW), .MSB_FIRST(1'b0)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus0.slave),
      .sel       (sel[0]),
      .busy      (busy[0]),
      .dbg_state (st[0])
   );

   mux_scan_serializer #(.WIDTH(W), .SEL_W(SW), .MSB_FIRST(1'b1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus1.slave),
      .sel       (sel[1]),
      .busy      (busy[1]),
      .dbg_state (st[1])
   );

   // ---------------- scoreboard ----------------
   // Entry layout: {last, bit, sel}
   logic [6:0] exp_q0[$];
   logic [6:0] exp_q1[$];
   logic [6:0] got_q0[$];
   logic [6:0] got_q1[$];
   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always @(posedge clk) begin
      if (rst_n && out_valid[0] && out_ready[0]) got_q0.push_back({out_last[0], out_bit[0], sel[0]});
      if (rst_n && out_valid[1] && out_ready[1]) got_q1.push_back({out_last[1], out_bit[1], sel[1]});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (got === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int d, input logic [6:0] e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // Reference: instance 1 walks bit indices 31,30,.. and instance 0 walks 0,1,..
   task automatic model_word(input int d, input logic [31:0] w, input int len);
      logic       p;
      logic       b;
      logic       last;
      logic [4:0] idx;
      p   = 1'b0;
      idx = '0;
      for (int k = 0; k <= len; k++) begin
         idx = (d == 1) ? 5'(31 - k) : 5'(k);
         b   = w[idx];
         p   = p ^ b;
`ifdef SERIAL_PARITY_EN
         last = 1'b0;
`else
         last = (k == len);
`endif
         push_exp(d, {last, b, idx});
      end
`ifdef SERIAL_PARITY_EN
      push_exp(d, {1'b1, p, idx});
`endif
   endtask

   task automatic check_stream(input int d, input string tag);
      logic [6:0] g[$];
      logic [6:0] e[$];
      if (d == 0) begin
         g = got_q0; e = exp_q0; got_q0.delete(); exp_q0.delete();
      end else begin
         g = got_q1; e = exp_q1; got_q1.delete(); exp_q1.delete();
      end
      chk({tag, " beat count"}, g.size(), e.size());
      for (int i = 0; i < e.size(); i++) begin
         if (i < g.size()) chk($sformatf("%s beat %0d", tag, i), g[i], e[i]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rnd_rdy(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic send(input int d, input logic [31:0] w, input logic [4:0] len, input int pct);
      int n;
      model_word(d, w, int'(len));
      in_data[d]  = w;
      in_len[d]   = len;
      in_valid[d] = 1'b1;
      n = 0;
      while (!in_ready[d] && n < DRAIN_MAX) begin
         out_ready[d] = rnd_rdy(pct);
         step();
         n++;
      end
      chk("accept within bound", n < DRAIN_MAX, 1);
      step();
      in_valid[d]  = 1'b0;
      in_data[d]   = $urandom;
      in_len[d]    = 5'($urandom);
      out_ready[d] = rnd_rdy(pct);
   endtask

   task automatic drain(input int d, input int pct, output int cycles);
      cycles = 0;
      while (busy[d] && cycles < DRAIN_MAX) begin
         step();
         cycles++;
         out_ready[d] = rnd_rdy(pct);
      end
      chk("drain within bound", cycles < DRAIN_MAX, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int         cyc;
      int         n;
      int         d;
      int         pct;
      logic       hold_bit;
      logic [4:0] hold_sel;
      logic       was_hold;
      logic [4:0] len;

      for (int i = 0; i < 2; i++) begin
         in_data[i] = '0; in_len[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset / idle
      repeat (3) step();
      chk("in_ready in reset", in_ready[0], 0);
      chk("out_valid in reset", out_valid[0], 0);
      rst_n = 1'b1;
      step();
      chk("idle out_valid0", out_valid[0], 0);
      chk("idle out_valid1", out_valid[1], 0);
      chk("idle busy0", busy[0], 0);
      chk("idle sel0", sel[0], 0);
      chk("idle sel1", sel[1], 31);
      chk("idle in_ready0", in_ready[0], 1);
      chk("idle in_ready1", in_ready[1], 1);
      chk("idle out_last0", out_last[0], 0);
      chk("idle out_bit0", out_bit[0], 0);
      chk("idle state0", st[0], IDLE);

      // Full 32-bit word, LSB first, consumer always ready
      out_ready[0] = 1'b1;
      send(0, 32'd640, 5'd31, 100);
      chk("first bit latency", out_valid[0], 1);
      chk("first sel", sel[0], 0);
      drain(0, 100, cyc);
`ifdef SERIAL_PARITY_EN
      chk("full word busy cycles", cyc, 33);
`else
      chk("full word busy cycles", cyc, 32);
`endif
      check_stream(0, "full word");

      // Backpressure: out_ready toggles, bits must hold while stalled
      send(0, 32'h0000_00A5, 5'd7, 100);
      for (int c = 0; c < 40 && busy[0]; c++) begin
         out_ready[0] = c[0];
         hold_bit = out_bit[0];
         hold_sel = sel[0];
         was_hold = out_valid[0] && !out_ready[0];
         step();
         if (was_hold) begin
            chk("stall out_bit", out_bit[0], hold_bit);
            chk("stall sel", sel[0], hold_sel);
            chk("stall out_valid", out_valid[0], 1);
         end
      end
      chk("backpressure done", busy[0], 0);
      check_stream(0, "backpressure");

      // Back-to-back on the MSB-first instance
      out_ready[1] = 1'b1;
      send(1, 32'h8000_0000, 5'd31, 100);
      model_word(1, 32'h0000_0001, 0);
      in_data[1]  = 32'h0000_0001;
      in_len[1]   = 5'd0;
      in_valid[1] = 1'b1;
      n = 0;
      while (!in_ready[1] && n < DRAIN_MAX) begin
         step();
         n++;
      end
`ifdef SERIAL_PARITY_EN
      chk("b2b accept cycle", n, 32);
`else
      chk("b2b accept cycle", n, 31);
`endif
      chk("b2b accept on last", out_last[1], 1);
      chk("b2b accept with valid", out_valid[1], 1);
      step();
      in_valid[1] = 1'b0;
      chk("b2b no bubble valid", out_valid[1], 1);
      chk("b2b no bubble busy", busy[1], 1);
      chk("b2b restart sel", sel[1], 31);
      drain(1, 100, cyc);
      check_stream(1, "back to back");

      // Reset in the middle of a word
      out_ready[0] = 1'b1;
      send(0, $urandom, 5'd31, 100);
      repeat (10) step();
      #2 rst_n = 1'b0;
      #1;
      chk("abort out_valid", out_valid[0], 0);
      chk("abort busy", busy[0], 0);
      chk("abort in_ready", in_ready[0], 0);
      while (exp_q0.size() > 10) void'(exp_q0.pop_back());
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post abort in_ready", in_ready[0], 1);
      chk("post abort sel", sel[0], 0);
      check_stream(0, "abort");
      send(0, 32'hFFFF_FFFF, 5'd3, 100);
      drain(0, 100, cyc);
      check_stream(0, "ones after abort");

`ifdef SERIAL_PARITY_EN
      // Parity beat carries out_last
      send(0, 32'h0000_0007, 5'd2, 100);
      drain(0, 100, cyc);
      check_stream(0, "parity odd");
      send(0, 32'h0000_0003, 5'd1, 100);
      drain(0, 100, cyc);
      check_stream(0, "parity even");
`endif

      // Random words, random lengths, random consumer stalls
      for (int i = 0; i < 24; i++) begin
         d   = i % 2;
         pct = int'($urandom_range(100, 40));
         len = (i < 4) ? 5'(i * 31 / 3) : 5'($urandom_range(31));
         send(d, $urandom, len, pct);
         drain(d, pct, cyc);
         check_stream(d, $sformatf("random %0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
